// File: rtl/backing_store_scheduler.sv
// Round-robin arbiter and burst sequencer sharing one backing store between
// line-fill and writeback requesters; each grant becomes one aligned burst.
module backing_store_scheduler #(
  parameter int unsigned NUM_REQ    = 3,
  parameter int unsigned ADDR_WIDTH = 25,
  parameter int unsigned WORD_BYTES = 2,
  parameter int unsigned BURST_LEN  = 8,
  localparam int unsigned DW        = 8 * WORD_BYTES,
  localparam int unsigned IDW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int unsigned LB        = $clog2(BURST_LEN)
) (
  input  logic                          backing_clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DW-1:0]         wr_data,
  output logic [NUM_REQ-1:0]            wr_pop,
  output logic                          rd_valid,
  output logic [DW-1:0]                 rd_data,
  output logic [IDW-1:0]                rd_id,
  output logic                          rd_last,
  output logic                          busy,
  output logic                          backing_store_cmd_valid,
  output logic [ADDR_WIDTH-1:0]         backing_store_address,
  output logic                          backing_store_we,
  output logic [DW-1:0]                 backing_store_wdata,
  input  logic                          backing_store_drdy,
  input  logic [DW-1:0]                 backing_store_rdata
);

  typedef enum logic [1:0] {StIdle, StReadCmd, StReadWait, StWrite} state_e;

  state_e                state_q;
  logic [IDW-1:0]        rr_ptr_q;
  logic [IDW-1:0]        id_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [LB:0]           beat_q;
  logic                  rd_valid_q;
  logic                  rd_last_q;
  logic [DW-1:0]         rd_data_q;
  logic [IDW-1:0]        rd_id_q;

  logic                  grant_any;
  logic [IDW-1:0]        winner;
  logic [IDW:0]          search_idx;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic                  last_beat;

  // Search starts just after the previous winner, wrapping at NUM_REQ.
  always_comb begin
    grant_any  = 1'b0;
    winner     = '0;
    search_idx = '0;
    for (int i = 1; i <= int'(NUM_REQ); i++) begin
      search_idx = {1'b0, rr_ptr_q} + (IDW+1)'(i);
      if (search_idx >= (IDW+1)'(NUM_REQ)) begin
        search_idx = search_idx - (IDW+1)'(NUM_REQ);
      end
      if (!grant_any && req_valid[search_idx[IDW-1:0]]) begin
        grant_any = 1'b1;
        winner    = search_idx[IDW-1:0];
      end
    end
  end

  assign win_addr  = req_addr[32'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
  assign last_beat = (beat_q == (LB+1)'(BURST_LEN - 1));

  always_comb begin
    req_ready = '0;
    if (!reset && (state_q == StIdle) && grant_any) begin
      req_ready[winner] = 1'b1;
    end
  end

  // Store-side outputs decode straight from registered state; reset masks them
  // so an abandoned burst produces nothing during the reset cycle either.
  always_comb begin
    backing_store_cmd_valid = 1'b0;
    backing_store_we        = 1'b0;
    backing_store_address   = '0;
    backing_store_wdata     = '0;
    wr_pop                  = '0;
    if (!reset) begin
      unique case (state_q)
        StReadCmd: begin
          backing_store_cmd_valid = 1'b1;
          backing_store_address   = base_q;
        end
        StWrite: begin
          backing_store_cmd_valid = 1'b1;
          backing_store_we        = 1'b1;
          backing_store_address   = {base_q[ADDR_WIDTH-1:LB], beat_q[LB-1:0]};
          backing_store_wdata     = wr_data[32'(id_q)*DW +: DW];
          wr_pop[id_q]            = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy     = !reset && (state_q != StIdle);
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign rd_id    = rd_id_q;
  assign rd_last  = rd_last_q;

  always_ff @(posedge backing_clk) begin
    if (reset) begin
      state_q    <= StIdle;
      rr_ptr_q   <= IDW'(NUM_REQ - 1);
      id_q       <= '0;
      base_q     <= '0;
      beat_q     <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      rd_data_q  <= '0;
      rd_id_q    <= '0;
    end else begin
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      rd_data_q  <= '0;
      rd_id_q    <= '0;
      unique case (state_q)
        StIdle: begin
          if (grant_any) begin
            id_q     <= winner;
            rr_ptr_q <= winner;
            base_q   <= win_addr & ~ADDR_WIDTH'(BURST_LEN - 1);
            beat_q   <= '0;
            state_q  <= req_we[winner] ? StWrite : StReadCmd;
          end
        end
        StReadCmd: state_q <= StReadWait;
        StReadWait: begin
          if (backing_store_drdy) begin
            rd_valid_q <= 1'b1;
            rd_data_q  <= backing_store_rdata;
            rd_id_q    <= id_q;
            beat_q     <= beat_q + 1'b1;
            if (last_beat) begin
              rd_last_q <= 1'b1;
              state_q   <= StIdle;
            end
          end
        end
        StWrite: begin
          beat_q <= beat_q + 1'b1;
          if (last_beat) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_backing_store_scheduler.sv
// Directed bench for backing_store_scheduler: per-cycle vector table for the
// basic bursts, plus hand sequences for round-robin, mid-burst reset, back-to-back.
module tb_backing_store_scheduler;
  localparam int NR = 3;
  localparam int AW = 25;
  localparam int DW = 16;

  logic               backing_clk = 1'b0;
  logic               reset;
  logic [NR-1:0]      req_valid, req_we, req_ready, wr_pop;
  logic [NR*AW-1:0]   req_addr;
  logic [NR*DW-1:0]   wr_data;
  logic               rd_valid, rd_last, busy, cmd_valid, bs_we, drdy;
  logic [DW-1:0]      rd_data, wdata, rdata;
  logic [1:0]         rd_id;
  logic [AW-1:0]      address;

  backing_store_scheduler dut (
    .backing_clk             (backing_clk),
    .reset                   (reset),
    .req_valid               (req_valid),
    .req_we                  (req_we),
    .req_addr                (req_addr),
    .req_ready               (req_ready),
    .wr_data                 (wr_data),
    .wr_pop                  (wr_pop),
    .rd_valid                (rd_valid),
    .rd_data                 (rd_data),
    .rd_id                   (rd_id),
    .rd_last                 (rd_last),
    .busy                    (busy),
    .backing_store_cmd_valid (cmd_valid),
    .backing_store_address   (address),
    .backing_store_we        (bs_we),
    .backing_store_wdata     (wdata),
    .backing_store_drdy      (drdy),
    .backing_store_rdata     (rdata)
  );

  always #5 backing_clk = ~backing_clk;

  typedef struct {
    logic          rst;
    logic [2:0]    v;
    logic [2:0]    we;
    logic          dr;
    logic [15:0]   rdat;
    logic [2:0]    rdy;
    logic [2:0]    pop;
    logic          cv;
    logic          bwe;
    logic [24:0]   addr;
    logic [15:0]   wd;
    logic          rv;
    logic [15:0]   rdd;
    logic [1:0]    rid;
    logic          rl;
    logic          bsy;
  } vec_t;

  vec_t        vecs[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int unsigned pop_cnt[NR];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Each requester presents base + (words popped so far) as its current write word.
  task automatic set_wdata();
    for (int i = 0; i < NR; i++) begin
      wr_data[i*DW +: DW] = ((i == 2) ? 16'h1000 : 16'h3000 + 16'(i * 256)) + 16'(pop_cnt[i]);
    end
  endtask

  task automatic advance();
    logic [NR-1:0] p;
    p = wr_pop;
    @(posedge backing_clk);
    #1;
    for (int i = 0; i < NR; i++) if (p[i]) pop_cnt[i]++;
    set_wdata();
  endtask

  task automatic do_reset();
    reset = 1'b1; req_valid = '0; req_we = '0; drdy = 1'b0; rdata = '0;
    advance();
    advance();
    reset = 1'b0;
  endtask

  task automatic add(input logic rst, input logic [2:0] v, input logic [2:0] we,
                     input logic dr, input logic [15:0] rdat, input logic [2:0] rdy,
                     input logic [2:0] pop, input logic cv, input logic bwe,
                     input logic [24:0] addr, input logic [15:0] wd, input logic rv,
                     input logic [15:0] rdd, input logic [1:0] rid, input logic rl,
                     input logic bsy);
    vec_t r;
    r.rst = rst; r.v = v; r.we = we; r.dr = dr; r.rdat = rdat; r.rdy = rdy; r.pop = pop;
    r.cv = cv; r.bwe = bwe; r.addr = addr; r.wd = wd; r.rv = rv; r.rdd = rdd; r.rid = rid;
    r.rl = rl; r.bsy = bsy;
    vecs.push_back(r);
  endtask

  initial begin
    logic [2:0] exp_order[4];
    int         gcount;

    for (int i = 0; i < NR; i++) pop_cnt[i] = 0;
    req_addr = '0;
    req_addr[0*AW +: AW] = 25'h000123;
    req_addr[1*AW +: AW] = 25'h000205;
    req_addr[2*AW +: AW] = 25'h000040;
    set_wdata();
    do_reset();

    // Reset held, then drdy in IDLE.
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 16'h55, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Read burst, requester 0, unaligned address.
    add(0, 3'b001, 0, 0, 0, 3'b001, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 1, 0, 25'h120, 0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 8; k++)
      add(0, 0, 0, 1, 16'hA0 + 16'(k), 0, 0, 0, 0, 0, 0, k > 0,
          (k > 0) ? 16'hA0 + 16'(k - 1) : 16'h0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'hA7, 0, 1, 0);
    // Write burst, requester 2, with drdy noise throughout.
    add(0, 3'b100, 3'b100, 0, 0, 3'b100, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 8; k++)
      add(0, 0, 0, 1, 16'hEE, 0, 3'b100, 1, 1, 25'h40 + 25'(k), 16'h1000 + 16'(k),
          0, 0, 0, 0, 1);
    add(0, 0, 0, 1, 16'hEE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Read burst, requester 1; drdy during READ_CMD must not count.
    add(0, 3'b010, 0, 0, 0, 3'b010, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 16'h77, 0, 0, 1, 0, 25'h200, 0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 8; k++)
      add(0, 0, 0, 1, 16'hB0 + 16'(k), 0, 0, 0, 0, 0, 0, k > 0,
          (k > 0) ? 16'hB0 + 16'(k - 1) : 16'h0, (k > 0) ? 2'd1 : 2'd0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'hB7, 1, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      reset = vecs[i].rst; req_valid = vecs[i].v; req_we = vecs[i].we;
      drdy = vecs[i].dr; rdata = vecs[i].rdat;
      @(negedge backing_clk);
      chk($sformatf("row%0d req_ready", i), req_ready, vecs[i].rdy);
      chk($sformatf("row%0d wr_pop", i), wr_pop, vecs[i].pop);
      chk($sformatf("row%0d cmd_valid", i), cmd_valid, vecs[i].cv);
      chk($sformatf("row%0d we", i), bs_we, vecs[i].bwe);
      chk($sformatf("row%0d address", i), address, vecs[i].addr);
      chk($sformatf("row%0d wdata", i), wdata, vecs[i].wd);
      chk($sformatf("row%0d rd_valid", i), rd_valid, vecs[i].rv);
      chk($sformatf("row%0d rd_data", i), rd_data, vecs[i].rdd);
      chk($sformatf("row%0d rd_id", i), rd_id, vecs[i].rid);
      chk($sformatf("row%0d rd_last", i), rd_last, vecs[i].rl);
      chk($sformatf("row%0d busy", i), busy, vecs[i].bsy);
      advance();
    end

    // Round-robin: all three read requests held, drdy always high.
    do_reset();
    exp_order[0] = 3'b001; exp_order[1] = 3'b010; exp_order[2] = 3'b100;
    exp_order[3] = 3'b001;
    gcount = 0;
    req_valid = 3'b111; req_we = 3'b000; drdy = 1'b1; rdata = 16'hCC;
    for (int c = 0; c < 38; c++) begin
      @(negedge backing_clk);
      if (busy) begin
        chk($sformatf("rr cycle%0d grant while busy", c), req_ready, 3'b000);
      end else if (req_ready != 3'b000) begin
        if (gcount < 4) chk($sformatf("rr grant%0d", gcount), req_ready, exp_order[gcount]);
        gcount++;
      end
      advance();
    end
    chk("rr grant count", 64'(gcount), 64'd4);

    // Reset after 3 of 8 read beats; later drdy must be ignored.
    do_reset();
    req_valid = 3'b001;
    @(negedge backing_clk);
    chk("mid-reset grant", req_ready, 3'b001);
    advance();
    req_valid = 3'b000;
    @(negedge backing_clk);
    chk("mid-reset cmd_valid", cmd_valid, 1'b1);
    advance();
    for (int k = 0; k < 3; k++) begin
      drdy = 1'b1; rdata = 16'hD0 + 16'(k);
      advance();
    end
    reset = 1'b1; drdy = 1'b0;
    advance();
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drdy = 1'b1; rdata = 16'hD3 + 16'(k);
      @(negedge backing_clk);
      chk($sformatf("post-reset rd_valid%0d", k), rd_valid, 1'b0);
      chk($sformatf("post-reset busy%0d", k), busy, 1'b0);
      advance();
    end
    drdy = 1'b0; req_valid = 3'b011;
    @(negedge backing_clk);
    chk("post-reset grant", req_ready, 3'b001);
    chk("post-reset rd_valid final", rd_valid, 1'b0);
    advance();

    // Write burst then pending read from requester 1.
    do_reset();
    req_valid = 3'b100; req_we = 3'b100;
    @(negedge backing_clk);
    chk("b2b write grant", req_ready, 3'b100);
    advance();
    req_valid = 3'b010; req_we = 3'b000;
    for (int k = 1; k <= 8; k++) begin
      @(negedge backing_clk);
      chk($sformatf("b2b T+%0d no grant", k), req_ready, 3'b000);
      chk($sformatf("b2b T+%0d wr_pop", k), wr_pop, 3'b100);
      advance();
    end
    @(negedge backing_clk);
    chk("b2b T+9 read grant", req_ready, 3'b010);
    chk("b2b T+9 wr_pop", wr_pop, 3'b000);
    advance();
    req_valid = 3'b000;
    @(negedge backing_clk);
    chk("b2b T+10 cmd_valid", cmd_valid, 1'b1);
    chk("b2b T+10 address", address, 25'h200);
    chk("b2b T+10 we", bs_we, 1'b0);
    advance();

    do_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/backing_store_scheduler.md
Name: backing_store_scheduler

Overview:
- Backing-clock-domain arbiter and burst sequencer that shares one backing store between NUM_REQ requesters: port A line fill, port B line fill, and dirty-line writeback/sync.
- Grants one requester at a time, round-robin.
- Converts each grant into one burst of BURST_LEN words: a read command plus collection of drdy beats, or BURST_LEN write beats.
- Sits between the writeback cache's line-fill/evict logic and the backing store pins.

Parameters:
NUM_REQ, 3, number of requesters (index 0 = port A fill, 1 = port B fill, 2 = writeback)
ADDR_WIDTH, 25, backing store word address width
WORD_BYTES, 2, backing store word size in bytes; DW = 8*WORD_BYTES
BURST_LEN, 8, words per burst (power of 2, >=2)

Ports:
backing_clk  in  1  clock
reset  in  1  synchronous active-high reset
req_valid  in  NUM_REQ  per-requester request; held until req_ready
req_we  in  NUM_REQ  1 = write burst, 0 = read burst
req_addr  in  NUM_REQ*ADDR_WIDTH  per-requester burst start word address
req_ready  out  NUM_REQ  one-hot grant pulse, combinational
wr_data  in  NUM_REQ*DW  per-requester current write word
wr_pop  out  NUM_REQ  write word consumed this cycle; requester advances next cycle
rd_valid  out  1  registered read beat valid
rd_data  out  DW  registered read beat data
rd_id  out  clog2(NUM_REQ)  owner of the read beat
rd_last  out  1  final beat of the burst
busy  out  1  state != IDLE
backing_store_cmd_valid  out  1  address/we valid this cycle
backing_store_address  out  ADDR_WIDTH  word address
backing_store_we  out  1  write strobe
backing_store_wdata  out  DW  write data
backing_store_drdy  in  1  read data valid
backing_store_rdata  in  DW  read data

Behaviour:
- States: IDLE, READ_CMD, READ_WAIT, WRITE.
- Reset: state IDLE; rr_ptr = NUM_REQ-1, so requester 0 wins first. All outputs 0, including rd_valid, rd_last, cmd_valid, we, address, wdata, req_ready, wr_pop, busy.
- Reset mid-burst: the burst is abandoned with no further beats, pops or rd_valid. drdy arriving after reset is ignored.
- IDLE, cycle T with any req_valid: the winner is the first set bit searching from rr_ptr+1 modulo NUM_REQ.
  - req_ready[winner] = 1 during T.
  - Latched: id = winner, we, base = req_addr with the low log2(BURST_LEN) bits forced to 0; beat = 0; rr_ptr <= winner.
  - Next state: WRITE if we, else READ_CMD.
  - No req_valid: stay IDLE, all outputs 0.
- READ_CMD, T+1: cmd_valid = 1, we = 0, address = base. Next state READ_WAIT.
- READ_WAIT:
  - Each cycle with drdy = 1 registers rd_data = rdata, rd_id = id, rd_valid = 1 in the next cycle, and increments beat.
  - On the BURST_LEN-th drdy, rd_last = 1 on the same registered beat and the state goes to IDLE.
  - No timeout; the state waits indefinitely for drdy.
- WRITE, cycles T+1 .. T+BURST_LEN:
  - cmd_valid = 1, we = 1, address = base + beat (wraps modulo BURST_LEN within the aligned block), wdata = wr_data[id], wr_pop[id] = 1.
  - After beat BURST_LEN-1, go to IDLE.
  - Back-to-back: the next grant is possible at T+BURST_LEN+1.
- drdy outside READ_WAIT (IDLE, READ_CMD, WRITE) is ignored: no rd_valid, no count change.
- Requests arriving while busy are not granted. Requesters must hold req_valid/req_addr/req_we stable until req_ready.
- Simultaneous requests: exactly one req_ready bit is set. Round-robin guarantees each pending requester is granted within NUM_REQ grants.
- All address arithmetic is ADDR_WIDTH wide. The beat counter is log2(BURST_LEN)+1 bits.
- wr_pop and req_ready are never asserted for non-granted requesters.

Test Plan:
- Read to req 0 at addr 0x000123 (cycle T) → cmd_valid at T+1 with address 0x000120, we = 0.
  - 8 drdy beats with rdata 0xA0..0xA7 → rd_valid beats carry 0xA0..0xA7, rd_id = 0, rd_last only on 0xA7; busy drops the cycle after.
- Write from req 2 at addr 0x40 with wr_data 0x1000..0x1007 → 8 consecutive cycles with we = 1, address 0x40..0x47, wdata in order, wr_pop[2] high for exactly 8 cycles.
- req_valid = 3'b111 all reads held continuously → grant order 0, 1, 2, 0; one req_ready bit per grant; no grant while busy.
- drdy pulsed during IDLE and during a WRITE burst → rd_valid stays 0, and the subsequent read still requires 8 beats.
- Reset asserted after 3 of 8 read beats, then drdy pulsed 5 more times → no rd_valid after reset, busy = 0, next grant goes to requester 0.
- Write grant followed immediately by a pending read from req 1 → read req_ready at cycle T+9, cmd_valid at T+10.
